// File: rtl/clockworks.sv
// clockworks: board-clock gearbox and reset stretcher.
// Divides CLK by 2^SLOW to make the slow system clock clk, and holds the
// active-low resetn low for 2^RESET_BITS-1 slow-clock periods after power-up
// or after RESET is released.
module clockworks #(
   parameter int SLOW       = 0,
   parameter int RESET_BITS = 4
) (
   input  logic CLK,
   input  logic RESET,
   output logic clk,
   output logic resetn
);

   // Reject nonsensical parameters while the design is being elaborated.
   if (SLOW < 0) begin : g_bad_slow
      $error("clockworks: SLOW must be >= 0");
   end
   if (RESET_BITS < 1) begin : g_bad_reset_bits
      $error("clockworks: RESET_BITS must be >= 1");
   end

   // High in the last CLK cycle of each slow-clock period.
   logic wrap;

   if (SLOW > 0) begin : g_div
      // Power-up value of zero starts the reset sequence without RESET.
      logic [SLOW-1:0] div = '0;

      // Free-running divider, cleared by RESET so clk is forced low.
      always_ff @(posedge CLK) begin
         if (RESET) begin
            div <= '0;
         end else begin
            div <= div + 1'b1;
         end
      end

      // MSB of the divider is a 50% duty square wave straight from a register.
      assign clk  = div[SLOW-1];
      assign wrap = &div;
   end else begin : g_nodiv
      // No division: the slow clock is the board clock and every cycle wraps.
      assign clk  = CLK;
      assign wrap = 1'b1;
   end

   // Reset-stretch counter; zero at power-up so resetn starts low.
   logic [RESET_BITS-1:0] rcnt = '0;

   // Count slow-clock periods until saturation; RESET wins over a wrap.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rcnt <= '0;
      end else if (wrap && !(&rcnt)) begin
         rcnt <= rcnt + 1'b1;
      end
   end

   // Decoded purely from register bits. rcnt only changes as div wraps to
   // zero (clk falling), so resetn is stable around clk rising edges.
   assign resetn = &rcnt;

endmodule

// File: tb/tb_clockworks.sv
// tb_clockworks: scoreboard bench for clockworks.
// Two instances share CLK and RESET: A (SLOW=3, RESET_BITS=2) and
// B (SLOW=0, RESET_BITS=4). The reference model only tracks how many CLK
// edges have passed since RESET was last sampled high, and derives clk and
// resetn from that count with plain arithmetic.
module tb_clockworks;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic clk_a, resetn_a;
   logic clk_b, resetn_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int edge_no;
      bit clk_a;
      bit resetn_a;
      bit resetn_b;
   } exp_t;

   exp_t sb[$];

   // Edges since last RESET-high sample (power-up counts as such an edge).
   int n = 0;
   int edge_total = 0;
   bit stim_done = 0;

   clockworks #(.SLOW(3), .RESET_BITS(2)) dut_a (
      .CLK    (CLK),
      .RESET  (RESET),
      .clk    (clk_a),
      .resetn (resetn_a)
   );

   clockworks #(.SLOW(0), .RESET_BITS(4)) dut_b (
      .CLK    (CLK),
      .RESET  (RESET),
      .clk    (clk_b),
      .resetn (resetn_b)
   );

   always #5 CLK = ~CLK;

   task automatic check_bit(input string name, input int edge_no,
                            input bit actual, input bit expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s edge %0d: got %0b expected %0b", name, edge_no, actual, expected);
      end
   endtask

   // Drive RESET for one CLK edge, advance the model, and queue the
   // expected outputs that should be visible after that edge.
   task automatic step(input bit r);
      exp_t e;
      RESET = r;
      @(posedge CLK);
      edge_total++;
      if (r) n = 0;
      else   n = n + 1;
      e.edge_no  = edge_total;
      e.clk_a    = ((n % 8) >= 4);
      e.resetn_a = (n >= 3 * 8);
      e.resetn_b = (n >= 15);
      sb.push_back(e);
      #1;
   endtask

   task automatic run_low(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0);
   endtask

   // Stimulus process.
   initial begin
      #1;
      // Reset state before any edge.
      check_bit("init_clk_a", 0, clk_a, 1'b0);
      check_bit("init_resetn_a", 0, resetn_a, 1'b0);
      check_bit("init_resetn_b", 0, resetn_b, 1'b0);

      // Power-up sequence without RESET.
      run_low(40);

      // Single-cycle pulse, then the full stretch.
      step(1'b1);
      run_low(29);
      // Reassert at E30 for 5 cycles, then release.
      for (int i = 0; i < 5; i++) step(1'b1);
      run_low(40);

      // RESET sampled exactly when the divider wraps (E16 after a pulse).
      step(1'b1);
      run_low(15);
      step(1'b1);
      run_low(30);

      // Long run with no reset: saturation and steady toggling.
      run_low(1000);

      // Randomized RESET activity.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 19) == 0);
      end
      run_low(30);
      stim_done = 1;
   end

   // Monitor: on every falling CLK edge, pop the expectation for the
   // preceding rising edge and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_bit("clk_a", e.edge_no, clk_a, e.clk_a);
            check_bit("resetn_a", e.edge_no, resetn_a, e.resetn_a);
            check_bit("resetn_b", e.edge_no, resetn_b, e.resetn_b);
            check_bit("clk_b_low", e.edge_no, clk_b, CLK);
         end
      end
   end

   // With SLOW=0 the slow clock must follow CLK high as well.
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         check_bit("clk_b_high", edge_total, clk_b, 1'b1);
      end
   end

   // Completion with a hard time bound.
   initial begin
      fork
         begin
            wait (stim_done);
            repeat (3) @(posedge CLK);
            #1;
            checks++;
            if (sb.size() != 0) begin
               errors++;
               $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
            end
         end
         begin
            #500000;
            checks++;
            errors++;
            $display("FAIL timeout: stimulus not complete, edges %0d", edge_total);
         end
      join_any
      disable fork;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
